procm6_in_fifo: RTL and testbench

Input sample buffer directly upstream of the `procm6` processor core. It accepts signed 32-bit samples from the acquisition side with a valid/full handshake and stores them in a first-word-fall-through FIFO. It presents the head sample on the processor's `in` port and advances one entry each cycle the core raises its input request (`req_in == 2'd1`). It replaces the file-reading stimulus used in simulation with synthesizable logic, and flags overflow and underflow.

---
 rtl/procm6_pkg.sv | 9 +
 rtl/procm6_in_fifo_if.sv | 29 ++
 rtl/procm6_sdp_ram.sv | 23 ++
 rtl/procm6_in_fifo.sv | 97 +++++++++
 tb/tb_procm6_in_fifo.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/procm6_pkg.sv
// Shared definitions for the procm6 input/output sample paths.
package procm6_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] REQ_NONE = 2'd0;
  localparam logic [1:0] REQ_POP  = 2'd1;

endpackage

// File: rtl/procm6_in_fifo_if.sv
// Acquisition-side write handshake plus procm6-side pop/status signals.
interface procm6_in_fifo_if #(
  parameter int unsigned DATA_W = procm6_pkg::DATA_W,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
);

  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_en;
  logic                     full;
  logic [1:0]               req_in;
  logic signed [DATA_W-1:0] in;
  logic                     empty;
  logic [CNT_W-1:0]         level;
  logic                     ovf;
  logic                     udf;
  logic                     clr_err;

  modport master (
    output wr_data, wr_en, req_in, clr_err,
    input  full, in, empty, level, ovf, udf
  );

  modport slave (
    input  wr_data, wr_en, req_in, clr_err,
    output full, in, empty, level, ovf, udf
  );

endinterface

// File: rtl/procm6_sdp_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read with enable (old data on collision).
module procm6_sdp_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/procm6_in_fifo.sv
// FWFT sample FIFO feeding the procm6 core's `in` port, with sticky overflow/underflow flags.
module procm6_in_fifo #(
  parameter int unsigned DATA_W = procm6_pkg::DATA_W,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  procm6_in_fifo_if.slave bus
);

  import procm6_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, raddr;
  logic [CNT_W-1:0]         level_q, level_d;
  logic                     full_q, vis_q, vis_d, ovf_q, ovf_d, udf_q, udf_d, byp_q, byp_d;
  logic signed [DATA_W-1:0] out_q, out_d, wdat_q, wdat_d, ahead;
  logic [DATA_W-1:0]        rdata;
  logic                     pop_req, pop, we;

  // RAM continuously reads the entry behind the next head, so a pop can
  // load the output register at the same edge it is sampled.
  procm6_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .re_i    (1'b1),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    pop_req  = (bus.req_in == REQ_POP);
    pop      = pop_req && vis_q;
    we       = bus.wr_en && (!full_q || pop);
    wr_ptr_d = we  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    raddr    = rd_ptr_d + AW'(1);
    level_d  = level_q + CNT_W'(we) - CNT_W'(pop);
    wdat_d   = we ? bus.wr_data : wdat_q;
    // A write landing on the read-ahead address is not visible in rdata until
    // the following read, so the last write data stands in for it.
    byp_d    = we && (wr_ptr_q == raddr);
    ahead    = byp_q ? wdat_q : $signed(rdata);

    out_d = out_q;
    vis_d = vis_q;
    if (pop) begin
      if (level_q >= CNT_W'(2)) out_d = ahead;
      else                      vis_d = 1'b0;
    end else if (!vis_q && level_q != '0) begin
      // Head is invisible only right after it was written, so it is the last write.
      out_d = wdat_q;
      vis_d = 1'b1;
    end

    ovf_d = (bus.wr_en && !we) ? 1'b1 : (bus.clr_err ? 1'b0 : ovf_q);
    udf_d = (pop_req && !vis_q) ? 1'b1 : (bus.clr_err ? 1'b0 : udf_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      vis_q    <= 1'b0;
      out_q    <= '0;
      wdat_q   <= '0;
      byp_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == CNT_W'(DEPTH));
      vis_q    <= vis_d;
      out_q    <= out_d;
      wdat_q   <= wdat_d;
      byp_q    <= byp_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.full  = full_q;
  assign bus.in    = out_q;
  assign bus.empty = !vis_q;
  assign bus.level = level_q;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;

endmodule

// File: tb/tb_procm6_in_fifo.sv
// Directed and randomized checks of procm6_in_fifo against a queue-based reference model.
module tb_procm6_in_fifo;

  import procm6_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  procm6_in_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  procm6_in_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: stored samples in order, whether the head is visible on `in`,
  // the value on `in`, and the sticky flags.
  logic [31:0] mq [$];
  bit          m_vis;
  logic [31:0] m_in;
  bit          m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_vis = 1'b0;
    m_in  = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_edge(input bit w, input logic [31:0] d, input logic [1:0] r, input bit c);
    bit pop_req, pop_ok, wr_ok;
    int n;
    n       = mq.size();
    pop_req = (r == REQ_POP);
    pop_ok  = pop_req && m_vis;
    wr_ok   = w && (n < DEPTH || pop_ok);
    if (w && !wr_ok)          m_ovf = 1'b1;
    else if (c)               m_ovf = 1'b0;
    if (pop_req && !m_vis)    m_udf = 1'b1;
    else if (c)               m_udf = 1'b0;
    if (pop_ok) begin
      void'(mq.pop_front());
      if (n >= 2) m_in = mq[0];
      else        m_vis = 1'b0;
    end else if (!m_vis && n >= 1) begin
      m_vis = 1'b1;
      m_in  = mq[0];
    end
    if (wr_ok) mq.push_back(d);
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".level"}, 32'(bus.level), 32'(mq.size()));
    chk({ph, ".full"},  32'(bus.full),  32'(mq.size() == DEPTH));
    chk({ph, ".empty"}, 32'(bus.empty), 32'(!m_vis));
    chk({ph, ".in"},    bus.in,         m_in);
    chk({ph, ".ovf"},   32'(bus.ovf),   32'(m_ovf));
    chk({ph, ".udf"},   32'(bus.udf),   32'(m_udf));
  endtask

  task automatic step(input string ph, input bit w, input logic [31:0] d,
                      input logic [1:0] r, input bit c);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.req_in  = r;
    bus.clr_err = c;
    @(posedge clk);
    model_edge(w, d, r, c);
    #1;
    check_all(ph);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.req_in  = REQ_NONE;
    bus.clr_err = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.in_zero", bus.in, 32'd0);
    rst = 1'b1;

    // 5, -7, 100 then three pops and one underflow pop
    step("wr", 1'b1, 32'd5, REQ_NONE, 1'b0);
    step("wr", 1'b1, -32'sd7, REQ_NONE, 1'b0);
    step("wr", 1'b1, 32'd100, REQ_NONE, 1'b0);
    chk("tp1.level", 32'(bus.level), 32'd3);
    chk("tp1.in", bus.in, 32'd5);
    step("pop", 1'b0, '0, REQ_POP, 1'b0);
    chk("tp2.in1", bus.in, -32'sd7);
    step("pop", 1'b0, '0, REQ_POP, 1'b0);
    chk("tp2.in2", bus.in, 32'd100);
    step("pop", 1'b0, '0, REQ_POP, 1'b0);
    chk("tp2.empty", 32'(bus.empty), 32'd1);
    chk("tp2.udf0", 32'(bus.udf), 32'd0);
    step("udf", 1'b0, '0, REQ_POP, 1'b0);
    chk("tp2.udf1", 32'(bus.udf), 32'd1);
    chk("tp2.hold", bus.in, 32'd100);
    step("clr", 1'b0, '0, REQ_NONE, 1'b1);

    // Overflow: 17 writes into a 16-entry FIFO
    for (int i = 0; i < 17; i++) begin
      step("fill", 1'b1, 32'(i), REQ_NONE, 1'b0);
      if (i == 15) chk("tp3.full", 32'(bus.full), 32'd1);
    end
    chk("tp3.ovf", 32'(bus.ovf), 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk("tp3.order", bus.in, 32'(k));
      step("drain", 1'b0, '0, REQ_POP, 1'b0);
    end
    step("clr", 1'b0, '0, REQ_NONE, 1'b1);

    // Full FIFO with simultaneous write and pop
    for (int i = 0; i < 16; i++) step("fill2", 1'b1, 32'(200 + i), REQ_NONE, 1'b0);
    step("wrpop", 1'b1, 32'd999, REQ_POP, 1'b0);
    chk("tp4.level", 32'(bus.level), 32'd16);
    chk("tp4.ovf", 32'(bus.ovf), 32'd0);
    for (int k = 0; k < 16; k++) begin
      chk("tp4.order", bus.in, (k < 15) ? 32'(201 + k) : 32'd999);
      step("drain2", 1'b0, '0, REQ_POP, 1'b0);
    end

    // Request codes 2 and 3 are no-ops
    step("wr", 1'b1, 32'd11, REQ_NONE, 1'b0);
    step("wr", 1'b1, 32'd22, REQ_NONE, 1'b0);
    step("idle", 1'b0, '0, REQ_NONE, 1'b0);
    step("req2", 1'b0, '0, 2'd2, 1'b0);
    chk("tp5.in2", bus.in, 32'd11);
    step("req3", 1'b0, '0, 2'd3, 1'b0);
    chk("tp5.level3", 32'(bus.level), 32'd2);

    // Build level 9 with udf set, then reset asynchronously mid-cycle
    step("pop", 1'b0, '0, REQ_POP, 1'b0);
    step("pop", 1'b0, '0, REQ_POP, 1'b0);
    step("udf", 1'b0, '0, REQ_POP, 1'b0);
    for (int i = 0; i < 9; i++) step("fill9", 1'b1, $urandom, REQ_NONE, 1'b0);
    step("idle", 1'b0, '0, REQ_NONE, 1'b0);
    chk("tp6.level9", 32'(bus.level), 32'd9);
    chk("tp6.udf", 32'(bus.udf), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("tp6.in_zero", bus.in, 32'd0);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;

    // Randomized traffic alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 1000; i++) begin
      int unsigned wp;
      bit          w, c;
      logic [1:0]  r;
      wp = ((i % 200) < 100) ? 70 : 30;
      w  = ($urandom_range(0, 99) < wp);
      if ($urandom_range(0, 99) < (100 - wp)) r = REQ_POP;
      else                                    r = 2'($urandom_range(0, 3));
      c  = ($urandom_range(0, 19) == 0);
      step("rand", w, $urandom, r, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
